// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, forwarding and halt-drain controller for a 5-stage MIPS pipeline.
// Latch enables/flushes and forwarded operands are combinational; halt and statistics are registered.
module pipeline_hazard_ctrl #(
  parameter int DATA_W       = 32,
  parameter int REG_W        = 5,
  parameter int BRANCH_STAGE = 2,
  parameter int DRAIN_CYC    = 1,
  parameter int CNT_W        = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              mem_req,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  ex_rs,
  input  logic [REG_W-1:0]  ex_rt,
  input  logic [DATA_W-1:0] ex_rdat1,
  input  logic [DATA_W-1:0] ex_rdat2,
  input  logic [REG_W-1:0]  ex_wsel,
  input  logic              ex_reg_wr,
  input  logic              ex_is_load,
  input  logic [REG_W-1:0]  mem_wsel,
  input  logic              mem_reg_wr,
  input  logic [DATA_W-1:0] mem_wdat,
  input  logic [REG_W-1:0]  wb_wsel,
  input  logic              wb_reg_wr,
  input  logic [DATA_W-1:0] wb_wdat,
  input  logic              br_taken,
  input  logic              halt_mem,
  output logic              fetch_en,
  output logic              decode_en,
  output logic              execute_en,
  output logic              memory_en,
  output logic              f_flush,
  output logic              d_flush,
  output logic              e_flush,
  output logic              pc_en,
  output logic              pc_redirect,
  output logic [DATA_W-1:0] fwd_dat1,
  output logic [DATA_W-1:0] fwd_dat2,
  output logic              halt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // state  | meaning
  // RUN    | normal issue, hazards resolved by fixed priority
  // DRAIN  | front end squashed while older work retires through MEM/WB
  // HALTED | pipeline frozen, halt asserted until reset
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [2:0]       DRAIN_INIT = 3'(DRAIN_CYC);
  localparam logic             E_FLUSH_BR = (BRANCH_STAGE == 3);

  state_t     state;
  logic [2:0] drain_cnt;

  logic busy;
  logic hold;
  logic lu;
  logic br;
  logic br_act;
  logic halt_go;
  logic stall_ev;
  logic flush_ev;

  assign busy    = mem_req & ~dhit;
  assign hold    = busy | (state != RUN);
  assign lu      = id_valid & ex_reg_wr & ex_is_load & (ex_wsel != '0) &
                   ((ex_wsel == id_rs) | (ex_wsel == id_rt));
  assign br      = br_taken & ~hold;
  assign halt_go = (state == RUN) & halt_mem & ~busy;

  // A halt in EX/MEM outranks a taken branch, so the branch never counts as a flush.
  assign br_act   = br & ~halt_mem;
  assign flush_ev = br_act;
  assign stall_ev = busy | (~halt_mem & ~br_act & (lu | ~ihit));

  always_comb begin
    fetch_en    = 1'b0;
    decode_en   = 1'b0;
    execute_en  = 1'b0;
    memory_en   = 1'b0;
    f_flush     = 1'b0;
    d_flush     = 1'b0;
    e_flush     = 1'b0;
    pc_en       = 1'b0;
    pc_redirect = 1'b0;
    unique case (state)
      RUN: begin
        if (!busy) begin
          decode_en  = 1'b1;
          execute_en = 1'b1;
          memory_en  = 1'b1;
          if (halt_mem) begin
            f_flush = 1'b1;
            d_flush = 1'b1;
          end else if (br) begin
            pc_redirect = 1'b1;
            f_flush     = 1'b1;
            d_flush     = 1'b1;
            e_flush     = E_FLUSH_BR;
          end else if (lu) begin
            d_flush = 1'b1;
          end else if (!ihit) begin
            f_flush = 1'b1;
          end else begin
            fetch_en = 1'b1;
            pc_en    = 1'b1;
          end
        end
      end
      DRAIN: begin
        memory_en = 1'b1;
        f_flush   = 1'b1;
        d_flush   = 1'b1;
        e_flush   = 1'b1;
      end
      default: ;
    endcase
  end

  // EX/MEM is the younger producer, so it wins over MEM/WB.
  always_comb begin
    fwd_dat1 = ex_rdat1;
    if (mem_reg_wr && (mem_wsel == ex_rs) && (ex_rs != '0))
      fwd_dat1 = mem_wdat;
    else if (wb_reg_wr && (wb_wsel == ex_rs) && (ex_rs != '0))
      fwd_dat1 = wb_wdat;
  end

  always_comb begin
    fwd_dat2 = ex_rdat2;
    if (mem_reg_wr && (mem_wsel == ex_rt) && (ex_rt != '0))
      fwd_dat2 = mem_wdat;
    else if (wb_reg_wr && (wb_wsel == ex_rt) && (ex_rt != '0))
      fwd_dat2 = wb_wdat;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= RUN;
      drain_cnt <= '0;
      halt      <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (stall_ev && (stall_cnt != CNT_MAX))
            stall_cnt <= stall_cnt + 1'b1;
          if (flush_ev && (flush_cnt != CNT_MAX))
            flush_cnt <= flush_cnt + 1'b1;
          if (halt_go) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_INIT;
          end
        end
        DRAIN: begin
          if (drain_cnt <= 3'd1) begin
            state     <= HALTED;
            halt      <= 1'b1;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end
        HALTED: halt <= 1'b1;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two configurations checked each cycle against an action-table model,
// with directed scenarios followed by randomized traffic.
module tb_pipeline_hazard_ctrl;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int BS [2] = '{2, 3};
  localparam int DC [2] = '{2, 3};
  localparam int CW [2] = '{3, 16};

  logic CLK = 1'b0;
  logic nRST;
  logic ihit, dhit, mem_req, id_valid;
  logic [RW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_wsel, mem_wsel, wb_wsel;
  logic [DW-1:0] ex_rdat1, ex_rdat2, mem_wdat, wb_wdat;
  logic ex_reg_wr, ex_is_load, mem_reg_wr, wb_reg_wr, br_taken, halt_mem;

  logic [1:0] fetch_en, decode_en, execute_en, memory_en;
  logic [1:0] f_flush, d_flush, e_flush, pc_en, pc_redirect, halt;
  logic [1:0][DW-1:0] fwd1, fwd2;
  logic [2:0]  stall_a, flush_a;
  logic [15:0] stall_b, flush_b;

  int total = 0;
  int bad = 0;

  int m_mode [2];
  int m_left [2];
  int m_halt [2];
  int m_stall [2];
  int m_flush [2];

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.BRANCH_STAGE(2), .DRAIN_CYC(2), .CNT_W(3)) dut_a (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rdat1(ex_rdat1), .ex_rdat2(ex_rdat2),
    .ex_wsel(ex_wsel), .ex_reg_wr(ex_reg_wr), .ex_is_load(ex_is_load), .mem_wsel(mem_wsel),
    .mem_reg_wr(mem_reg_wr), .mem_wdat(mem_wdat), .wb_wsel(wb_wsel), .wb_reg_wr(wb_reg_wr),
    .wb_wdat(wb_wdat), .br_taken(br_taken), .halt_mem(halt_mem),
    .fetch_en(fetch_en[0]), .decode_en(decode_en[0]), .execute_en(execute_en[0]), .memory_en(memory_en[0]),
    .f_flush(f_flush[0]), .d_flush(d_flush[0]), .e_flush(e_flush[0]), .pc_en(pc_en[0]),
    .pc_redirect(pc_redirect[0]), .fwd_dat1(fwd1[0]), .fwd_dat2(fwd2[0]), .halt(halt[0]),
    .stall_cnt(stall_a), .flush_cnt(flush_a));

  pipeline_hazard_ctrl #(.BRANCH_STAGE(3), .DRAIN_CYC(3), .CNT_W(16)) dut_b (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rdat1(ex_rdat1), .ex_rdat2(ex_rdat2),
    .ex_wsel(ex_wsel), .ex_reg_wr(ex_reg_wr), .ex_is_load(ex_is_load), .mem_wsel(mem_wsel),
    .mem_reg_wr(mem_reg_wr), .mem_wdat(mem_wdat), .wb_wsel(wb_wsel), .wb_reg_wr(wb_reg_wr),
    .wb_wdat(wb_wdat), .br_taken(br_taken), .halt_mem(halt_mem),
    .fetch_en(fetch_en[1]), .decode_en(decode_en[1]), .execute_en(execute_en[1]), .memory_en(memory_en[1]),
    .f_flush(f_flush[1]), .d_flush(d_flush[1]), .e_flush(e_flush[1]), .pc_en(pc_en[1]),
    .pc_redirect(pc_redirect[1]), .fwd_dat1(fwd1[1]), .fwd_dat2(fwd2[1]), .halt(halt[1]),
    .stall_cnt(stall_b), .flush_cnt(flush_b));

  task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Action codes: 0 freeze, 1 halt entry, 2 branch, 3 load-use, 4 icache miss, 5 normal, 6 drain, 7 halted
  function automatic int action(int i);
    logic lu;
    lu = id_valid && ex_reg_wr && ex_is_load && (ex_wsel != 0) && ((ex_wsel == id_rs) || (ex_wsel == id_rt));
    if (m_mode[i] == 1) return 6;
    if (m_mode[i] == 2) return 7;
    if (mem_req && !dhit) return 0;
    if (halt_mem) return 1;
    if (br_taken) return 2;
    if (lu) return 3;
    if (!ihit) return 4;
    return 5;
  endfunction

  // Bit order: fetch, decode, execute, memory, f_flush, d_flush, e_flush, pc_en, pc_redirect
  function automatic logic [8:0] exp_ctl(int i);
    logic [8:0] tbl [8];
    int a;
    tbl = '{9'b000000000, 9'b011111000, 9'b011111001, 9'b011101000,
            9'b011110000, 9'b111100010, 9'b000111100, 9'b000000000};
    a = action(i);
    if (a == 2 && BS[i] == 3) return 9'b011111101;
    return tbl[a];
  endfunction

  function automatic logic [DW-1:0] exp_fwd(logic [RW-1:0] rs, logic [DW-1:0] rdat);
    logic [DW-1:0] v;
    v = rdat;
    if (wb_reg_wr && wb_wsel == rs && rs != 0) v = wb_wdat;
    if (mem_reg_wr && mem_wsel == rs && rs != 0) v = mem_wdat;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_left[i] = 0; m_halt[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
    end
  endtask

  task automatic model_advance();
    if (!nRST) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      int a;
      int mx;
      a = action(i);
      mx = (1 << CW[i]) - 1;
      if (m_mode[i] == 0) begin
        if ((a == 0 || a == 3 || a == 4) && m_stall[i] < mx) m_stall[i]++;
        if (a == 2 && m_flush[i] < mx) m_flush[i]++;
        if (a == 1) begin m_mode[i] = 1; m_left[i] = DC[i]; end
      end else if (m_mode[i] == 1) begin
        if (m_left[i] <= 1) begin m_mode[i] = 2; m_halt[i] = 1; end
        else m_left[i]--;
      end
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 2; i++) begin
      logic [8:0] ctl;
      ctl = {fetch_en[i], decode_en[i], execute_en[i], memory_en[i], f_flush[i], d_flush[i],
             e_flush[i], pc_en[i], pc_redirect[i]};
      expect_eq($sformatf("ctl%0d", i), 64'(ctl), 64'(exp_ctl(i)));
      expect_eq($sformatf("fwd1_%0d", i), 64'(fwd1[i]), 64'(exp_fwd(ex_rs, ex_rdat1)));
      expect_eq($sformatf("fwd2_%0d", i), 64'(fwd2[i]), 64'(exp_fwd(ex_rt, ex_rdat2)));
      expect_eq($sformatf("halt%0d", i), 64'(halt[i]), 64'(m_halt[i]));
      expect_eq($sformatf("stall%0d", i), (i == 0) ? 64'(stall_a) : 64'(stall_b), 64'(m_stall[i]));
      expect_eq($sformatf("flush%0d", i), (i == 0) ? 64'(flush_a) : 64'(flush_b), 64'(m_flush[i]));
    end
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic tick();
    check_model();
    model_advance();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    nRST = 1'b1; ihit = 1'b1; dhit = 1'b1; mem_req = 1'b0; id_valid = 1'b0;
    id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_wsel = '0; mem_wsel = '0; wb_wsel = '0;
    ex_rdat1 = 32'h1111; ex_rdat2 = 32'h2222; mem_wdat = '0; wb_wdat = '0;
    ex_reg_wr = 1'b0; ex_is_load = 1'b0; mem_reg_wr = 1'b0; wb_reg_wr = 1'b0;
    br_taken = 1'b0; halt_mem = 1'b0;
  endtask

  task automatic set_lu(input logic [RW-1:0] wsel);
    id_valid = 1'b1; ex_reg_wr = 1'b1; ex_is_load = 1'b1; ex_wsel = wsel; id_rs = 5'd5; id_rt = 5'd9;
  endtask

  task automatic rand_inputs();
    nRST = ($urandom_range(0, 24) != 0);
    ihit = ($urandom_range(0, 3) != 0);
    dhit = ($urandom_range(0, 2) != 0);
    mem_req = ($urandom_range(0, 2) == 0);
    id_valid = ($urandom_range(0, 1) == 1);
    id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
    ex_rs = 5'($urandom_range(0, 7)); ex_rt = 5'($urandom_range(0, 7));
    ex_wsel = 5'($urandom_range(0, 7)); mem_wsel = 5'($urandom_range(0, 7));
    wb_wsel = 5'($urandom_range(0, 7));
    ex_rdat1 = $urandom; ex_rdat2 = $urandom; mem_wdat = $urandom; wb_wdat = $urandom;
    ex_reg_wr = ($urandom_range(0, 1) == 1); ex_is_load = ($urandom_range(0, 1) == 1);
    mem_reg_wr = ($urandom_range(0, 1) == 1); wb_reg_wr = ($urandom_range(0, 1) == 1);
    br_taken = ($urandom_range(0, 3) == 0);
    halt_mem = ($urandom_range(0, 29) == 0);
  endtask

  initial begin
    int s0;
    int f0;
    idle();
    nRST = 1'b0;
    @(posedge CLK);
    #1;
    model_reset();
    settle();
    expect_eq("rst_halt", 64'(halt[0]), 64'd0);
    expect_eq("rst_stall", 64'(stall_b), 64'd0);
    tick();
    nRST = 1'b1;

    // forwarding priority
    ex_rs = 5'd3; mem_wsel = 5'd3; mem_reg_wr = 1'b1; mem_wdat = 32'hAA;
    wb_wsel = 5'd3; wb_reg_wr = 1'b1; wb_wdat = 32'hBB; ex_rdat1 = 32'h77;
    settle();
    expect_eq("fwd_mem", 64'(fwd1[0]), 64'hAA);
    tick();
    mem_reg_wr = 1'b0;
    settle();
    expect_eq("fwd_wb", 64'(fwd1[0]), 64'hBB);
    tick();
    ex_rs = 5'd0;
    settle();
    expect_eq("fwd_r0", 64'(fwd1[1]), 64'h77);
    tick();

    // load-use interlock, then the $zero destination that must not stall
    idle();
    set_lu(5'd5);
    s0 = int'(stall_b);
    settle();
    expect_eq("lu_fetch", 64'(fetch_en[1]), 64'd0);
    expect_eq("lu_dflush", 64'(d_flush[1]), 64'd1);
    expect_eq("lu_pc", 64'(pc_en[1]), 64'd0);
    tick();
    idle();
    settle();
    expect_eq("lu_cnt", 64'(stall_b), 64'(s0 + 1));
    expect_eq("lu_once", 64'(fetch_en[1]), 64'd1);
    tick();
    set_lu(5'd0);
    settle();
    expect_eq("lu0_dflush", 64'(d_flush[1]), 64'd0);
    expect_eq("lu0_pc", 64'(pc_en[1]), 64'd1);
    tick();
    idle();
    settle();
    expect_eq("lu0_cnt", 64'(stall_b), 64'(s0 + 1));
    tick();

    // dcache miss freezes everything, branch then resolves
    mem_req = 1'b1; dhit = 1'b0; br_taken = 1'b1;
    repeat (4) begin
      settle();
      expect_eq("miss_en", 64'({fetch_en, decode_en, execute_en, memory_en}), 64'd0);
      expect_eq("miss_redir", 64'(pc_redirect), 64'd0);
      tick();
    end
    dhit = 1'b1;
    settle();
    expect_eq("br_redir", 64'(pc_redirect), 64'b11);
    expect_eq("br_eflush2", 64'(e_flush[0]), 64'd0);
    expect_eq("br_eflush3", 64'(e_flush[1]), 64'd1);
    tick();

    // branch and load-use together
    idle();
    set_lu(5'd5);
    br_taken = 1'b1;
    s0 = int'(stall_b);
    f0 = int'(flush_b);
    settle();
    expect_eq("brlu_redir", 64'(pc_redirect[1]), 64'd1);
    expect_eq("brlu_fetch", 64'(fetch_en[1]), 64'd0);
    expect_eq("brlu_dflush", 64'(d_flush[1]), 64'd1);
    tick();
    idle();
    settle();
    expect_eq("brlu_stall", 64'(stall_b), 64'(s0));
    expect_eq("brlu_flush", 64'(flush_b), 64'(f0 + 1));
    tick();

    // halt drain on dut_a (two drain cycles)
    halt_mem = 1'b1; br_taken = 1'b1;
    settle();
    expect_eq("hlt_redir", 64'(pc_redirect[0]), 64'd0);
    expect_eq("hlt_flush", 64'({f_flush[0], d_flush[0]}), 64'b11);
    tick();
    idle();
    repeat (2) begin
      settle();
      expect_eq("drain_en", 64'({fetch_en[0], decode_en[0], execute_en[0], memory_en[0], pc_en[0]}), 64'b00010);
      expect_eq("drain_halt", 64'(halt[0]), 64'd0);
      tick();
    end
    repeat (10) begin
      settle();
      expect_eq("halted", 64'(halt[0]), 64'd1);
      expect_eq("halted_en", 64'({fetch_en[0], decode_en[0], execute_en[0], memory_en[0], pc_en[0]}), 64'd0);
      tick();
    end
    nRST = 1'b0;
    settle();
    expect_eq("halt_pre_rst", 64'(halt[0]), 64'd1);
    tick();
    nRST = 1'b1;
    settle();
    expect_eq("halt_post_rst", 64'(halt), 64'd0);
    tick();

    // saturation of the 3-bit counter
    ihit = 1'b0;
    repeat (10) begin
      settle();
      tick();
    end
    settle();
    expect_eq("sat_a", 64'(stall_a), 64'd7);
    expect_eq("sat_b", 64'(stall_b), 64'd10);
    tick();

    repeat (3000) begin
      rand_inputs();
      settle();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
